uart_rx_mmio: RTL and testbench

UART receiver with an 8-entry receive FIFO, exposed to picorv32 as a memory-mapped responder on its native memory interface. It deserialises 8N1 frames arriving on the board's RS-232 receive pin, buffers the bytes and answers CPU loads and stores to a 16-byte register window. It also raises a level interrupt while data is pending. It sits inside `top`, alongside the core, on the same clock.

---
 rtl/uart_rx_mmio_if.sv | 25 ++
 rtl/uart_rx_mmio.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_mmio_if.sv
//------------------------------------------------------------------------------
// uart_rx_mmio_if : picorv32 native memory bus bundle (CPU = master). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_mmio_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_mmio.sv
//------------------------------------------------------------------------------
// uart_rx_mmio : 8N1 UART receiver + RX FIFO behind a picorv32 MMIO window.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_mmio_if.slave  bus,
  input  logic           rxd,
  output logic           irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } rx_state_t;

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, frame_set;
  logic          rx_meta, rx_s;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [NW-1:0] count;
  logic          overrun, frame_err, irq_en;

  logic          sel, is_read, pop_req, do_pop, do_push, full, not_empty;
  logic          clr_wr, ctrl_wr;
  logic [1:0]    reg_sel;
  logic [31:0]   status_word, read_word;
  logic          unused_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      S_IDLE: if (!rx_s) begin
        state_n = S_START;
        cnt_n   = HALF_LOAD;
      end
      S_START: if (cnt == '0) begin
        if (!rx_s) begin
          state_n = S_DATA;
          cnt_n   = FULL_LOAD;
          idx_n   = 3'd0;
        end else begin
          state_n = S_IDLE;
        end
      end else cnt_n = cnt - 1'b1;
      S_DATA: if (cnt == '0) begin
        shreg_n[idx] = rx_s;
        cnt_n        = FULL_LOAD;
        if (idx == 3'd7) state_n = S_STOP;
        else             idx_n   = idx + 3'd1;
      end else cnt_n = cnt - 1'b1;
      S_STOP: if (cnt == '0) begin
        if (rx_s) begin
          push    = 1'b1;
          state_n = S_IDLE;
        end else begin
          frame_set = 1'b1;
          state_n   = S_WAIT_IDLE;
        end
      end else cnt_n = cnt - 1'b1;
      // A held-low line (break) must return high before a new start bit counts.
      S_WAIT_IDLE: if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Blocking re-select while mem_ready is high prevents a second pop per access.
  assign sel       = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]) && !bus.mem_ready;
  assign is_read   = (bus.mem_wstrb == 4'b0000);
  assign reg_sel   = bus.mem_addr[3:2];
  assign full      = (count == DEPTH_N);
  assign not_empty = (count != '0);
  assign pop_req   = sel && is_read && (reg_sel == 2'd0);
  assign do_pop    = pop_req && not_empty;
  assign do_push   = push && (!full || do_pop);
  assign clr_wr    = sel && (reg_sel == 2'd1) && bus.mem_wstrb[0];
  assign ctrl_wr   = sel && (reg_sel == 2'd2) && bus.mem_wstrb[0];
  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[31:4], bus.mem_wdata[1], bus.mem_wstrb[3:1]};

  assign status_word = {19'd0, 5'(count), 4'd0, frame_err, overrun, full, not_empty};

  always_comb begin
    read_word = 32'd0;
    if (is_read) begin
      case (reg_sel)
        2'd0:    read_word = not_empty ? {24'd0, fifo_mem[rd_ptr]} : 32'hFFFF_FFFF;
        2'd1:    read_word = status_word;
        2'd2:    read_word = {31'd0, irq_en};
        default: read_word = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= 3'd0;
      shreg         <= 8'd0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
      irq_en        <= 1'b0;
      irq           <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A new event in the same cycle as a clear wins.
      if (push && full && !do_pop)            overrun <= 1'b1;
      else if (clr_wr && bus.mem_wdata[2])    overrun <= 1'b0;
      if (frame_set)                          frame_err <= 1'b1;
      else if (clr_wr && bus.mem_wdata[3])    frame_err <= 1'b0;
      if (ctrl_wr) irq_en <= bus.mem_wdata[0];

      irq           <= irq_en && not_empty;
      bus.mem_ready <= sel;
      bus.mem_rdata <= sel ? read_word : 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
//------------------------------------------------------------------------------
// tb_uart_rx_mmio : directed bench with a queue-based receiver/register model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_mmio;
  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic irq;

  uart_rx_mmio_if bus ();

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .rxd   (rxd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Model: received bytes, sticky flags and the interrupt enable.
  logic [7:0]  q[$];
  bit          m_ovr, m_ferr, m_irq_en;
  int          checks = 0;
  int          errors = 0;
  bit          chk_irq = 0;
  bit          pending = 0;
  logic [31:0] exp_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [4:0] n;
    bit ne, fu;
    n  = 5'(q.size());
    ne = (q.size() != 0);
    fu = (q.size() == 8);
    return {19'd0, n, 4'd0, m_ferr, m_ovr, fu, ne};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_ready) begin
        check("rdata", bus.mem_rdata, exp_rdata);
        check("ready_expected", {31'd0, pending}, 32'd1);
      end else begin
        check("rdata_idle", bus.mem_rdata, 32'd0);
      end
      if (chk_irq) check("irq_model", {31'd0, irq}, {31'd0, m_irq_en && (q.size() != 0)});
    end
  end

  task automatic access(input logic [3:0] off, input logic [3:0] wstrb, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic irq_rdy, output logic irq_after);
    logic [31:0] e;
    int lat;
    bit seen;
    chk_irq = 0;
    e = 32'd0;
    if (wstrb == 4'd0) begin
      case (off)
        4'h0:    e = (q.size() != 0) ? {24'd0, q[0]} : 32'hFFFF_FFFF;
        4'h4:    e = model_status();
        4'h8:    e = {31'd0, m_irq_en};
        default: e = 32'd0;
      endcase
    end
    exp_rdata = e;
    rd = 32'd0; irq_rdy = 1'b0; irq_after = 1'b0;
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE | {28'd0, off};
    bus.mem_wstrb = wstrb;
    bus.mem_wdata = wdata;
    pending = 1;
    seen = 0; lat = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_ready) begin
        seen = 1; rd = bus.mem_rdata; irq_rdy = irq;
      end
    end
    check("ready_seen", {31'd0, seen}, 32'd1);
    check("ready_latency", lat, 2);
    @(posedge clk); #1;
    pending = 0;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'd0;
    @(negedge clk);
    check("ready_single", {31'd0, bus.mem_ready}, 32'd0);
    irq_after = irq;
    if (wstrb == 4'd0 && off == 4'h0 && q.size() != 0) void'(q.pop_front());
    if (off == 4'h4 && wstrb[0]) begin
      if (wdata[2]) m_ovr = 0;
      if (wdata[3]) m_ferr = 0;
    end
    if (off == 4'h8 && wstrb[0]) m_irq_en = wdata[0];
    repeat (2) @(posedge clk); #1;
    chk_irq = 1;
  endtask

  task automatic rd_reg(input logic [3:0] off, output logic [31:0] d);
    logic a, b;
    access(off, 4'h0, 32'd0, d, a, b);
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] v);
    logic [31:0] d;
    logic a, b;
    access(off, 4'hF, v, d, a, b);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    chk_irq = 0;
    @(posedge clk); #1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
    if (stop) begin
      if (q.size() == 8) m_ovr = 1;
      else q.push_back(b);
    end else begin
      m_ferr = 1;
    end
    repeat (2) @(posedge clk); #1;
    chk_irq = 1;
  endtask

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] d;
    logic ir, ia;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wstrb = 4'd0;
    bus.mem_wdata = 32'd0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("reset_rdata", bus.mem_rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    chk_irq = 1;

    rd_reg(4'h4, d); check("status_after_reset", d, 32'h0000_0000);
    rd_reg(4'h0, d); check("data_empty", d, 32'hFFFF_FFFF);

    // A request outside the window must never be acknowledged.
    @(posedge clk); #1;
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h0300_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("unselected_ready", {31'd0, bus.mem_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;

    send_frame(8'hA5, 1'b1);
    rd_reg(4'h4, d); check("status_a5", d, 32'h0000_0101);
    rd_reg(4'h0, d); check("data_a5", d, 32'h0000_00A5);
    rd_reg(4'h4, d); check("status_drained", d, 32'h0000_0000);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    rd_reg(4'h4, d); check("status_overrun", d, 32'h0000_0807);
    for (int i = 1; i <= 8; i++) begin
      rd_reg(4'h0, d); check("data_fifo_order", d, 32'(i));
    end
    wr_reg(4'h4, 32'h4);
    rd_reg(4'h4, d); check("status_ovr_cleared", d, 32'h0000_0000);

    send_frame(8'hC3, 1'b0);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 20);
    send_frame(8'h3C, 1'b1);
    rd_reg(4'h4, d); check("status_frame_err", d, 32'h0000_0109);
    rd_reg(4'h0, d); check("data_after_break", d, 32'h0000_003C);
    wr_reg(4'h4, 32'h8);
    rd_reg(4'h4, d); check("status_ferr_cleared", d, 32'h0000_0000);

    @(posedge clk); #1;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    rd_reg(4'h4, d); check("status_glitch", d, 32'h0000_0000);

    wr_reg(4'h8, 32'h1);
    rd_reg(4'h8, d); check("ctrl_readback", d, 32'h0000_0001);
    send_frame(8'h55, 1'b1);
    check("irq_raised", {31'd0, irq}, 32'd1);
    access(4'h0, 4'h0, 32'd0, d, ir, ia);
    check("data_55", d, 32'h0000_0055);
    check("irq_at_ready", {31'd0, ir}, 32'd1);
    check("irq_after_ready", {31'd0, ia}, 32'd0);

    send_frame(8'h11, 1'b1);
    chk_irq = 0;
    @(posedge clk); #1;
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    #3 reset = 1'b1;
    rxd = 1'b1;
    q.delete();
    m_ovr = 0; m_ferr = 0; m_irq_en = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("irq_after_reset", {31'd0, irq}, 32'd0);
    repeat (12 * CPB) @(posedge clk); #1;
    chk_irq = 1;
    rd_reg(4'h4, d); check("status_after_midframe_reset", d, 32'h0000_0000);
    send_frame(8'h7E, 1'b1);
    rd_reg(4'h4, d); check("status_7e", d, 32'h0000_0101);
    rd_reg(4'h0, d); check("data_7e", d, 32'h0000_007E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
